// File: rtl/mmio_timer_gpio_if.sv
// mmio_timer_gpio_if: core load/store bus between a CPU and the timer/GPIO block
interface mmio_timer_gpio_if;
    logic        rd;
    logic [3:0]  we;
    logic [31:0] addr_in;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        hit;

    modport master (output rd, we, addr_in, data_in, input data_out, hit);
    modport slave  (input rd, we, addr_in, data_in, output data_out, hit);
endinterface

// File: rtl/mmio_timer_gpio.sv
// mmio_timer_gpio: memory-mapped LED/switch port plus prescaled compare timer with interrupt
module mmio_timer_gpio #(
    parameter logic [31:0] BASE     = 32'h0000_2000,
    parameter int          SW_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rstn,
    mmio_timer_gpio_if.slave    bus,
    input  logic [SW_WIDTH-1:0] sw,
    output logic [SW_WIDTH-1:0] led,
    output logic                irq
);
    logic [2:0]          sel;
    logic                wr;
    logic                en;
    logic                autoreload;
    logic                match_ie;
    logic                swchg_ie;
    logic [7:0]          prescale;
    logic [7:0]          presc;
    logic [7:0]          presc_next;
    logic [31:0]         count;
    logic [31:0]         count_next;
    logic [31:0]         compare;
    logic [1:0]          status;
    logic [1:0]          status_next;
    logic [1:0]          clr;
    logic                tick;
    logic                is_match;
    logic [31:0]         ctrl_word;
    logic [31:0]         led_word;
    logic [31:0]         cw;
    logic [31:0]         lw;
    logic [31:0]         rdata;
    logic [31:0]         data_reg;
    logic [SW_WIDTH-1:0] sw_meta;
    logic [SW_WIDTH-1:0] sw_sync;
    logic [SW_WIDTH-1:0] sw_hist;
    logic                unused_bits;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = be[i] ? d[i*8 +: 8] : old[i*8 +: 8];
        return r;
    endfunction

    assign bus.hit      = bus.addr_in[31:5] == BASE[31:5];
    assign bus.data_out = data_reg;
    assign sel          = bus.addr_in[4:2];
    assign wr           = bus.hit & (|bus.we);
    assign ctrl_word    = {16'h0, prescale, 4'h0, swchg_ie, match_ie, autoreload, en};
    assign led_word     = 32'(led);
    assign cw           = merge(ctrl_word, bus.data_in, bus.we);
    assign lw           = merge(led_word, bus.data_in, bus.we);
    assign irq          = (status[0] & match_ie) | (status[1] & swchg_ie);
    assign unused_bits  = ^{bus.addr_in[1:0], cw, lw};

    // timer datapath: prescaler tick, count update with bus-write priority, sticky status with set-over-clear
    always_comb begin
        tick        = en && presc == prescale;
        is_match    = tick && count == compare;
        presc_next  = (!en || tick) ? 8'd0 : presc + 8'd1;
        count_next  = (wr && sel == 3'd3) ? merge(count, bus.data_in, bus.we) :
                      (is_match && autoreload) ? 32'd0 :
                      tick ? count + 32'd1 : count;
        clr         = (wr && sel == 3'd5 && bus.we[0]) ? bus.data_in[1:0] : 2'b00;
        status_next = (status & ~clr) | {sw_sync != sw_hist, is_match};
    end

    // read mux, sampled before any same-cycle write lands
    always_comb begin
        rdata = 32'd0;
        case (sel)
            3'd0:    rdata = led_word;
            3'd1:    rdata = 32'(sw_sync);
            3'd2:    rdata = ctrl_word;
            3'd3:    rdata = count;
            3'd4:    rdata = compare;
            3'd5:    rdata = {30'd0, status};
            default: rdata = 32'd0;
        endcase
    end

    // switch synchronizer with history flop for change detection
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sw_meta <= '0;
            sw_sync <= '0;
            sw_hist <= '0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
            sw_hist <= sw_sync;
        end
    end

    // software-visible registers and timer state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            led        <= '0;
            en         <= 1'b0;
            autoreload <= 1'b0;
            match_ie   <= 1'b0;
            swchg_ie   <= 1'b0;
            prescale   <= 8'd0;
            presc      <= 8'd0;
            count      <= 32'd0;
            compare    <= 32'd0;
            status     <= 2'b00;
        end else begin
            presc  <= presc_next;
            count  <= count_next;
            status <= status_next;
            if (wr && sel == 3'd0) led <= lw[SW_WIDTH-1:0];
            if (wr && sel == 3'd2) begin
                en         <= cw[0];
                autoreload <= cw[1];
                match_ie   <= cw[2];
                swchg_ie   <= cw[3];
                prescale   <= cw[15:8];
            end
            if (wr && sel == 3'd4) compare <= merge(compare, bus.data_in, bus.we);
        end
    end

    // registered load data, zero on a miss, held between loads
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) data_reg <= 32'd0;
        else if (bus.rd) data_reg <= bus.hit ? rdata : 32'd0;
    end
endmodule

// File: doc/mmio_timer_gpio.md
MMIO_TIMER_GPIO -- requirements
Module: mmio_timer_gpio

Interface
REQ-001 Parameter BASE, 32'h0000_2000, block base address; 32-byte aligned.
REQ-002 Parameter SW_WIDTH, 16, width of switch and LED ports.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 rd  input  1  core load strobe, one cycle per access.
REQ-006 we  input  4  core store byte enables; we[i] writes byte i.
REQ-007 addr_in  input  32  core byte address.
REQ-008 data_in  input  32  core store data.
REQ-009 data_out  output  32  registered load data.
REQ-010 hit  output  1  combinational decode: addr_in[31:5] == BASE[31:5].
REQ-011 sw  input  SW_WIDTH  asynchronous board switches.
REQ-012 led  output  SW_WIDTH  LED register contents.
REQ-013 irq  output  1  level interrupt request.

Function
REQ-014 The block SHALL act only when hit=1; select the register with addr_in[4:2] and ignore addr_in[1:0].
REQ-015 The register map SHALL be: 0x00 LED (RW), 0x04 SW (RO), 0x08 CTRL (RW), 0x0C COUNT (RW), 0x10 COMPARE (RW), 0x14 STATUS (W1C), 0x18/0x1C read 0 and ignore writes.
REQ-016 CTRL SHALL hold bit0 EN, bit1 AUTORELOAD, bit2 MATCH_IE, bit3 SWCHG_IE, bits[15:8] PRESCALE; all other bits read 0.
REQ-017 Byte-enable writes SHALL update only enabled bytes; bits above the implemented register width SHALL be ignored and read as 0.
REQ-018 Load latency SHALL be one cycle: data_out takes the selected value at the clock edge where rd=1 and hit=1; it holds until the next load.
REQ-019 rd=1 with hit=0 SHALL load data_out with 0.
REQ-020 rd and a nonzero we in the same cycle SHALL perform the write; data_out SHALL return the pre-write value.
REQ-021 sw SHALL pass through a 2-flop synchronizer; the SW register returns the second flop.
REQ-022 Any change between the second flop and a third history flop SHALL set STATUS bit1 SWCHG.
REQ-023 With EN=1, an 8-bit prescaler SHALL count 0..PRESCALE and produce a tick on the cycle it equals PRESCALE, then return to 0. PRESCALE=0 SHALL tick every cycle.
REQ-024 With EN=0, the prescaler SHALL be held at 0 and COUNT frozen.
REQ-025 On each tick COUNT SHALL increment modulo 2^32, wrapping 0xFFFF_FFFF to 0.
REQ-026 On a tick where the pre-increment COUNT equals COMPARE, the block SHALL set STATUS bit0 MATCH; if AUTORELOAD=1, COUNT SHALL load 0 instead of incrementing.
REQ-027 A core write to COUNT SHALL take priority over a same-cycle tick update; the written value is used.
REQ-028 A write of 1 to a STATUS bit SHALL clear it; a hardware set in the same cycle SHALL win over the clear.
REQ-029 The block SHALL drive irq = (MATCH & MATCH_IE) | (SWCHG & SWCHG_IE), from registers with no combinational path from the bus.

Reset
REQ-030 While rstn=0, the block SHALL hold to 0: LED, CTRL, COUNT, COMPARE, STATUS, prescaler, data_out and irq. The synchronizer and history flops SHALL also reset to 0, so a nonzero sw sets SWCHG after release.
REQ-031 A reset asserted mid-count or mid-load SHALL abort it; no state from before reset survives.

Verification
REQ-032 Write LED 0x0000_A5A5 with we=4'b0001 after reset -> led=0x00A5; read LED -> data_out=0x0000_00A5 one cycle after rd.
REQ-033 Set CTRL=0x0000_0301 (PRESCALE=3, EN) and COMPARE=2 -> COUNT increments every 4 cycles. MATCH sets on the tick where COUNT goes 2->3; irq stays 0 because MATCH_IE=0.
REQ-034 Set CTRL AUTORELOAD+MATCH_IE+EN with PRESCALE=0 and COMPARE=5 -> COUNT sequence is 0..5,0,... and irq=1 from the first match. Writing STATUS=1 clears irq; it reasserts at the next match.
REQ-035 Set COUNT=0xFFFF_FFFF with EN, PRESCALE=0 -> the next tick gives COUNT=0. A same-cycle write COUNT=0x10 with a tick -> COUNT=0x10.
REQ-036 Toggle sw bit3 with SWCHG_IE set -> STATUS bit1 sets 3 cycles later and irq=1. A W1C on the same cycle as a new change -> bit stays 1.
REQ-037 Read addr BASE+0x40 (hit=0) -> data_out=0. Assert rstn=0 mid-count -> all outputs 0 immediately, without waiting for a clock.
